// File: rtl/sample_frame_rx_if.sv
// Receiver-side signal bundle for sample_frame_rx: serial input, strobe and the output word handshake.
interface sample_frame_rx_if #(
    parameter int unsigned NUM_BITS = 8
);
    logic                bit_en;
    logic                serial_in;
    logic [NUM_BITS-1:0] data_out;
    logic                data_valid;
    logic                data_ready;
    logic                framing_error;
    logic                overrun;
    logic                busy;

    modport master (
        output bit_en, serial_in, data_ready,
        input  data_out, data_valid, framing_error, overrun, busy
    );

    modport slave (
        input  bit_en, serial_in, data_ready,
        output data_out, data_valid, framing_error, overrun, busy
    );
endinterface

// File: rtl/sample_frame_rx.sv
// Strobe-sampled serial frame receiver (start, NUM_BITS data, optional even parity, stop) with a one-word output buffer.
// Optional parity stage is enabled by defining SAMPLE_FRAME_RX_PARITY_EN.
module sample_frame_rx #(
    parameter int unsigned NUM_BITS  = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    sample_frame_rx_if.slave rx
);
    localparam int unsigned CNT_W = $clog2(NUM_BITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
`ifdef SAMPLE_FRAME_RX_PARITY_EN
        ST_STOP   = 2'd2,
        ST_PARITY = 2'd3
`else
        ST_STOP   = 2'd2
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_BITS-1:0] shift_q, shift_d;
    logic [NUM_BITS-1:0] data_out_q, data_out_d;
    logic                data_valid_q, data_valid_d;
    logic                framing_error_q, framing_error_d;
    logic                overrun_q, overrun_d;
    logic                busy_q, busy_d;
    logic                frame_good;
    logic                consume;
`ifdef SAMPLE_FRAME_RX_PARITY_EN
    logic                par_q, par_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            shift_q         <= '1;
            data_out_q      <= '1;
            data_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
            busy_q          <= 1'b0;
`ifdef SAMPLE_FRAME_RX_PARITY_EN
            par_q           <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            shift_q         <= shift_d;
            data_out_q      <= data_out_d;
            data_valid_q    <= data_valid_d;
            framing_error_q <= framing_error_d;
            overrun_q       <= overrun_d;
            busy_q          <= busy_d;
`ifdef SAMPLE_FRAME_RX_PARITY_EN
            par_q           <= par_d;
`endif
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        shift_d         = shift_q;
        data_out_d      = data_out_q;
        data_valid_d    = data_valid_q;
        framing_error_d = 1'b0;
        overrun_d       = 1'b0;
        frame_good      = 1'b0;
        consume         = data_valid_q && rx.data_ready;
`ifdef SAMPLE_FRAME_RX_PARITY_EN
        par_d           = par_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (rx.bit_en && !rx.serial_in) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
`ifdef SAMPLE_FRAME_RX_PARITY_EN
                    par_d   = 1'b0;
`endif
                end
            end
            ST_DATA: begin
                if (rx.bit_en) begin
                    if (LSB_FIRST) shift_d = {rx.serial_in, shift_q[NUM_BITS-1:1]};
                    else           shift_d = {shift_q[NUM_BITS-2:0], rx.serial_in};
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef SAMPLE_FRAME_RX_PARITY_EN
                    par_d = par_q ^ rx.serial_in;
                    if (cnt_q == CNT_W'(NUM_BITS - 1)) state_d = ST_PARITY;
`else
                    if (cnt_q == CNT_W'(NUM_BITS - 1)) state_d = ST_STOP;
`endif
                end
            end
`ifdef SAMPLE_FRAME_RX_PARITY_EN
            ST_PARITY: begin
                if (rx.bit_en) begin
                    par_d   = par_q ^ rx.serial_in;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // A low stop bit is an error, never a fresh start bit.
                if (rx.bit_en) begin
                    state_d = ST_IDLE;
`ifdef SAMPLE_FRAME_RX_PARITY_EN
                    if (rx.serial_in && !par_q) frame_good = 1'b1;
`else
                    if (rx.serial_in) frame_good = 1'b1;
`endif
                    else framing_error_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Output buffer: load on free slot or same-cycle consume, otherwise drop with overrun.
        if (frame_good) begin
            if (!data_valid_q || consume) begin
                data_out_d   = shift_q;
                data_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (consume) begin
            data_valid_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign rx.data_out      = data_out_q;
    assign rx.data_valid    = data_valid_q;
    assign rx.framing_error = framing_error_q;
    assign rx.overrun       = overrun_q;
    assign rx.busy          = busy_q;
endmodule

// File: tb/tb_sample_frame_rx.sv
// Self-checking bench for sample_frame_rx: an LSB-first and an MSB-first instance driven in lockstep.
module tb_sample_frame_rx;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sample_frame_rx_if #(.NUM_BITS(8)) bus0 ();
    sample_frame_rx_if #(.NUM_BITS(8)) bus1 ();

    sample_frame_rx #(.NUM_BITS(8), .LSB_FIRST(1'b1)) dut0 (.clk(clk), .rst(rst), .rx(bus0.slave));
    sample_frame_rx #(.NUM_BITS(8), .LSB_FIRST(1'b0)) dut1 (.clk(clk), .rst(rst), .rx(bus1.slave));

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       rdy_stop;
        logic       exp_valid;
        logic       exp_fe;
        logic       exp_ovr;
        logic [7:0] exp_out;
        logic       push;
        logic       drain;
    } vec_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] sb_q[$];
    vec_t       vecs[8];

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic be, input logic si, input logic rdy);
        bus0.bit_en = be;  bus0.serial_in = si;  bus0.data_ready = rdy;
        bus1.bit_en = be;  bus1.serial_in = si;  bus1.data_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobed bit followed by an idle gap cycle.
    task automatic send_bit(input logic si);
        drive(1'b1, si, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b0);
        tick();
    endtask

    // Full frame; returns right after the edge that closes the stop-bit cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic rdy_stop, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef SAMPLE_FRAME_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        drive(1'b1, stop, rdy_stop);
        tick();
        drive(1'b0, 1'b1, 1'b0);
    endtask

    task automatic drain();
        drive(1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b1, 1'b0);
        check("drain_valid_clear", 32'(bus0.data_valid), 32'd0);
    endtask

    // Scoreboard consumer: a handshake is about to happen on the next edge.
    always @(negedge clk) begin
        if (!rst && bus0.data_valid && bus0.data_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_word", 32'(bus0.data_out), 32'hxx);
            end else begin
                logic [7:0] e;
                e = sb_q.pop_front();
                check("sb_word_lsb", 32'(bus0.data_out), 32'(e));
                check("sb_word_msb", 32'(bus1.data_out), 32'(rev8(e)));
            end
        end
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1};
        vecs[1] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[3] = '{8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0};
        vecs[4] = '{8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
        vecs[5] = '{8'h22, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1};
        vecs[6] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1};
        vecs[7] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0);
        #1;
        check("rst_data_out",  32'(bus0.data_out), 32'hFF);
        check("rst_valid",     32'(bus0.data_valid), 32'd0);
        check("rst_busy",      32'(bus0.busy), 32'd0);
        check("rst_fe",        32'(bus0.framing_error), 32'd0);
        check("rst_ovr",       32'(bus0.overrun), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Idle-level strobes must not start a frame.
        send_bit(1'b1);
        check("idle_high_busy", 32'(bus0.busy), 32'd0);

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].push) sb_q.push_back(vecs[v].exp_out);
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].rdy_stop, 1'b0);
            check($sformatf("v%0d_valid", v),   32'(bus0.data_valid), 32'(vecs[v].exp_valid));
            check($sformatf("v%0d_fe", v),      32'(bus0.framing_error), 32'(vecs[v].exp_fe));
            check($sformatf("v%0d_ovr", v),     32'(bus0.overrun), 32'(vecs[v].exp_ovr));
            check($sformatf("v%0d_out_lsb", v), 32'(bus0.data_out), 32'(vecs[v].exp_out));
            check($sformatf("v%0d_out_msb", v), 32'(bus1.data_out), 32'(rev8(vecs[v].exp_out)));
            check($sformatf("v%0d_busy", v),    32'(bus0.busy), 32'd0);
            tick();
            check($sformatf("v%0d_fe_pulse", v),  32'(bus0.framing_error), 32'd0);
            check($sformatf("v%0d_ovr_pulse", v), 32'(bus0.overrun), 32'd0);
            check($sformatf("v%0d_valid_hold", v), 32'(bus0.data_valid), 32'(vecs[v].exp_valid));
            if (vecs[v].drain) drain();
        end

        // Mid-frame reset after 4 data bits of 5A.
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("mid_busy", 32'(bus0.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy",  32'(bus0.busy), 32'd0);
        check("mid_rst_out",   32'(bus0.data_out), 32'hFF);
        check("mid_rst_valid", 32'(bus0.data_valid), 32'd0);
        check("mid_rst_fe",    32'(bus0.framing_error), 32'd0);
        check("mid_rst_ovr",   32'(bus0.overrun), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        check("post_rst_valid", 32'(bus0.data_valid), 32'd0);
        check("post_rst_fe",    32'(bus0.framing_error), 32'd0);
        sb_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        check("post_rst_5a_valid", 32'(bus0.data_valid), 32'd1);
        check("post_rst_5a_out",   32'(bus0.data_out), 32'h5A);
        drain();

`ifdef SAMPLE_FRAME_RX_PARITY_EN
        sb_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        check("par_good_valid", 32'(bus0.data_valid), 32'd1);
        check("par_good_out",   32'(bus0.data_out), 32'h07);
        drain();
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        check("par_bad_fe",    32'(bus0.framing_error), 32'd1);
        check("par_bad_valid", 32'(bus0.data_valid), 32'd0);
        tick();
`endif

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sample_frame_rx.md
SAMPLE_FRAME_RX -- requirements
Module: sample_frame_rx

Interface
REQ-001 The block SHALL provide parameter NUM_BITS, default 8, data bits per frame (legal 2..32).
REQ-002 The block SHALL provide parameter LSB_FIRST, default 1: 1 = first data bit lands in data_out[0]; 0 = first data bit lands in data_out[NUM_BITS-1].
REQ-003 Port: clk  input  1  single rising-edge clock for all state.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: bit_en  input  1  one-cycle strobe marking the cycle where serial_in holds a valid sampled bit.
REQ-006 Port: serial_in  input  1  serial line; idle level 1.
REQ-007 Port: data_out  output  NUM_BITS  last accepted frame payload.
REQ-008 Port: data_valid  output  1  data_out holds an unconsumed word.
REQ-009 Port: data_ready  input  1  consumer accepts data_out when data_valid && data_ready.
REQ-010 Port: framing_error  output  1  one-cycle pulse, bad stop bit (or parity, see REQ-030).
REQ-011 Port: overrun  output  1  one-cycle pulse, completed word dropped because output buffer full.
REQ-012 Port: busy  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, DATA, STOP (plus PARITY per REQ-029); all transitions occur only on cycles with bit_en=1, except reset.
REQ-014 IDLE: bit_en && serial_in=0 (start bit) -> DATA with bit counter cleared to 0; bit_en && serial_in=1 -> stay IDLE.
REQ-015 DATA: each bit_en shifts serial_in into an internal shift register per LSB_FIRST and increments the counter; on the NUM_BITS-th bit -> STOP (or PARITY).
REQ-016 The bit counter SHALL be $clog2(NUM_BITS+1) bits wide and never wrap during a frame.
REQ-017 STOP: bit_en && serial_in=1 -> frame good; bit_en && serial_in=0 -> framing_error pulse next cycle, word discarded; both -> IDLE.
REQ-018 A good frame SHALL be written to data_out and data_valid set on the clock edge after the stop-bit bit_en cycle (latency 1 cycle).
REQ-019 data_valid SHALL stay high, data_out stable, until a cycle with data_valid && data_ready; it then clears on the next edge.
REQ-020 Good frame completes while data_valid=1 and data_ready=0: word dropped, data_out unchanged, overrun pulses one cycle.
REQ-021 Good frame completes in the same cycle data_valid && data_ready: new word loaded, data_valid stays 1, no overrun.
REQ-022 bit_en cycles with data_ready activity SHALL not stall reception; the receive path never back-pressures.
REQ-023 A 0 on serial_in in STOP SHALL NOT be taken as a new start bit; the next start is recognised only from IDLE.
REQ-024 framing_error and overrun SHALL never assert in the same cycle as a data_valid rising edge caused by the same frame.

Reset
REQ-025 Asserting rst at any time, including mid-frame, SHALL immediately force: state IDLE, counter 0, shift register all 1s, data_out all 1s, data_valid 0, framing_error 0, overrun 0, busy 0.
REQ-026 A partially received frame at reset SHALL be lost; no output pulse results from it.
REQ-027 After rst deasserts, the first bit_en with serial_in=0 SHALL start a frame.

Configuration
REQ-028 Macro SAMPLE_FRAME_RX_PARITY_EN SHALL control an even-parity bit.
REQ-029 With SAMPLE_FRAME_RX_PARITY_EN defined: DATA -> PARITY after the last data bit; the next bit_en samples the parity bit -> STOP.
REQ-030 With it defined: XOR of data bits and parity bit = 1 marks the frame bad; at STOP it is discarded and framing_error pulses, regardless of stop bit value.
REQ-031 Without it: no PARITY state, no parity logic; frame = start + NUM_BITS data + stop.

Verification
REQ-032 NUM_BITS=8, LSB_FIRST=1, bits 0,(1,0,1,0,0,1,0,1),1 on consecutive bit_en -> data_out=8'hA5, data_valid=1 one cycle after stop bit.
REQ-033 Same frame, LSB_FIRST=0 -> data_out=8'hA5 bit-reversed = 8'hA5 replaced by test word 8'h01 sent LSB-first giving data_out=8'h80.
REQ-034 Frame 8'h3C with stop bit 0 -> framing_error one-cycle pulse, data_valid stays 0, busy 0 after.
REQ-035 Two good frames 8'h11 then 8'h22, data_ready=0 -> data_out=8'h11, overrun pulse on second; repeat with data_ready=1 at completion cycle -> data_out=8'h22, no overrun.
REQ-036 rst asserted after 4 data bits -> outputs per REQ-025 within same cycle; next full frame 8'h5A received correctly.
REQ-037 With SAMPLE_FRAME_RX_PARITY_EN, frame 8'h07 with parity 1 -> accepted; parity 0 -> framing_error, no data_valid.
